ledfader: RTL and testbench



---
 rtl/ledfader_if.sv | 12 +
 rtl/ledfader.sv | 93 +++++++++
 tb/tb_ledfader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ledfader_if.sv
// LED request / PWM drive bundle between the walker side and the fader.
interface ledfader_if #(
  parameter int NLEDS = 8,
  parameter int BW    = 4
);
  logic [NLEDS-1:0]    i_led;
  logic [NLEDS-1:0]    o_led;
  logic [NLEDS*BW-1:0] o_level;

  modport master (output i_led, input o_led, input o_level);
  modport slave  (input i_led, output o_led, output o_level);
endinterface

// File: rtl/ledfader.sv
// PWM LED fader: active inputs light at full brightness, then fade linearly to off.
// Optional LEDFADER_INPUT_SYNC_EN adds a two-flop synchronizer on i_led.
module ledfader_lane #(
  parameter int BW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          req,
  input  logic          decay_stb,
  input  logic [BW-1:0] pcnt,
  output logic [BW-1:0] level,
  output logic          pwm
);
  localparam logic [BW-1:0] MAX = '1;

  // Load beats decay; decay saturates at zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level <= '0;
      pwm   <= 1'b0;
    end else begin
      if (req)
        level <= MAX;
      else if (decay_stb && level != '0)
        level <= level - 1'b1;
      pwm <= (level > pcnt);
    end
  end
endmodule

module ledfader #(
  parameter int NLEDS     = 8,
  parameter int BW        = 4,
  parameter int DECAY_DIV = 500_000
) (
  input logic       i_clk,
  input logic       i_reset_n,
  ledfader_if.slave bus
);
  localparam int            DW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);
  localparam logic [BW-1:0] PLAST = BW'((2 ** BW) - 2);

  logic [DW-1:0]                dcnt;
  logic [BW-1:0]                pcnt;
  logic                         decay_stb;
  logic [NLEDS-1:0]             req;
  logic [NLEDS-1:0][BW-1:0]     level;
  logic [NLEDS-1:0]             pwm;

  assign decay_stb = (dcnt == DLAST);

  // Both counters free-run; input activity never restarts the decay phase.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dcnt <= '0;
      pcnt <= '0;
    end else begin
      dcnt <= decay_stb ? '0 : dcnt + 1'b1;
      pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
    end
  end

`ifdef LEDFADER_INPUT_SYNC_EN
  logic [1:0][NLEDS-1:0] sync_pipe;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      sync_pipe <= '0;
    else
      sync_pipe <= {sync_pipe[0], bus.i_led};
  end

  assign req = sync_pipe[1];
`else
  assign req = bus.i_led;
`endif

  for (genvar k = 0; k < NLEDS; k++) begin : g_lane
    ledfader_lane #(.BW(BW)) u_lane (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .req       (req[k]),
      .decay_stb (decay_stb),
      .pcnt      (pcnt),
      .level     (level[k]),
      .pwm       (pwm[k])
    );
  end

  assign bus.o_led   = pwm;
  assign bus.o_level = level;
endmodule

// File: tb/tb_ledfader.sv
// Directed bench for ledfader: reset, fade profile, duty, load-vs-decay, walker pattern.
module tb_ledfader;
  localparam int NL = 8;
  localparam int BW = 4;
`ifdef LEDFADER_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   ecnt      = 0;
  int   cnt;

  ledfader_if #(.NLEDS(NL), .BW(BW)) bus_a ();
  ledfader_if #(.NLEDS(NL), .BW(BW)) bus_b ();

  ledfader #(.NLEDS(NL), .BW(BW), .DECAY_DIV(4)) u_dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus_a)
  );

  ledfader #(.NLEDS(NL), .BW(BW), .DECAY_DIV(1000)) u_duty (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus_b)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Ends at the falling edge after the rising edge, so outputs are stable.
  task automatic tick;
    @(posedge i_clk);
    @(negedge i_clk);
    ecnt++;
  endtask

  task automatic reset_seq;
    i_reset_n   = 1'b0;
    bus_a.i_led = '0;
    bus_b.i_led = '0;
    repeat (3) tick;
    i_reset_n = 1'b1;
    ecnt      = 0;
  endtask

  // Level after edge n for a one-cycle pulse driven before edge 1, DECAY_DIV=4.
  function automatic int exp_lvl(input int n);
    int v;
    if (n < 1 + SL) return 0;
    v = 15 - n / 4;
    return (v < 0) ? 0 : v;
  endfunction

  initial begin
    // Reset held, then async reset mid-fade
    bus_a.i_led = '0;
    bus_b.i_led = '0;
    repeat (5) tick;
    chk("rst_led", bus_a.o_led, 0);
    chk("rst_lvl", bus_a.o_level, 0);
    i_reset_n   = 1'b1;
    ecnt        = 0;
    bus_a.i_led = 8'h04;
    tick;
    bus_a.i_led = '0;
    repeat (SL + 1) tick;
    chk("ld2_lvl", bus_a.o_level, 64'(exp_lvl(ecnt)) << 8);
    chk("ld2_led", bus_a.o_led, 8'h04);
    repeat (5) tick;
    chk("fade2_lvl", bus_a.o_level, 64'(exp_lvl(ecnt)) << 8);
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_led", bus_a.o_led, 0);
    chk("arst_lvl", bus_a.o_level, 0);
    @(negedge i_clk);

    // Single pulse, full fade profile and saturation at zero
    reset_seq;
    bus_a.i_led = 8'h01;
    for (int n = 1; n <= 70; n++) begin
      tick;
      bus_a.i_led = '0;
      chk($sformatf("pulse_lvl%0d", n), bus_a.o_level, 64'(exp_lvl(n)));
      chk($sformatf("pulse_led%0d", n), bus_a.o_led,
          (exp_lvl(n - 1) > ((n - 1) % 15)) ? 64'd1 : 64'd0);
    end

    // Load on the same edge as a decay strobe wins
    reset_seq;
    bus_a.i_led = 8'h08;
    tick;
    bus_a.i_led = '0;
    while (ecnt < 28) begin
      bus_a.i_led = (ecnt == 27 - SL) ? 8'h08 : 8'h00;
      tick;
      if (ecnt == 27) chk("sim_pre", bus_a.o_level, 64'd9 << 12);
    end
    bus_a.i_led = '0;
    chk("sim_ld", bus_a.o_level, 64'd15 << 12);
    while (ecnt < 32) tick;
    chk("sim_dec", bus_a.o_level, 64'd14 << 12);

    // Walker pattern
    reset_seq;
    for (int p = 0; p < 4; p++) begin
      bus_a.i_led = 8'(1 << p);
      repeat (8) tick;
    end
    bus_a.i_led = '0;
    repeat (SL) tick;
    chk("walk_lvl", bus_a.o_level, 64'h0000_fdb9);

    // Duty on the slow-decay instance, channel 5
    reset_seq;
    bus_b.i_led = 8'h20;
    tick;
    bus_b.i_led = '0;
    while (ecnt < 19) tick;
    cnt = 0;
    repeat (15) begin tick; cnt += int'(bus_b.o_led[5]); end
    chk("duty15", 64'(cnt), 15);
    while (ecnt < 8100) tick;
    chk("duty7_lvl", bus_b.o_level, 64'd7 << 20);
    cnt = 0;
    repeat (15) begin tick; cnt += int'(bus_b.o_led[5]); end
    chk("duty7", 64'(cnt), 7);
    while (ecnt < 15100) tick;
    chk("duty0_lvl", bus_b.o_level, 0);
    cnt = 0;
    repeat (15) begin tick; cnt += int'(bus_b.o_led[5]); end
    chk("duty0", 64'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
